// File: rtl/sha3_576_pkg.sv
// Shared constants for the 576-bit-rate SHA3 absorb front end.
// Byte lane k of a 64-bit word lives at bits [63-8k -: 8].
package sha3_576_pkg;

    localparam int RATE_WORDS = 9;
    localparam int WORD_BITS  = 64;
    localparam int RATE_BITS  = RATE_WORDS * WORD_BITS;

    localparam logic [7:0] PAD_BYTE  = 8'h06;
    localparam logic [7:0] FINAL_BIT = 8'h80;

    function automatic int lane_hi(input int k);
        return WORD_BITS - 1 - 8 * k;
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Masks the final message word and drops the domain byte right
// after the last valid byte.
module sha3_pad_word
    import sha3_576_pkg::*;
(
    input  logic [63:0] in,
    input  logic [2:0]  byte_num,
    output logic [63:0] out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(byte_num))
                out[lane_hi(k) -: 8] = in[lane_hi(k) -: 8];
            else if (k == int'(byte_num))
                out[lane_hi(k) -: 8] = PAD_BYTE;
        end
    end

endmodule

// File: rtl/sha3_576_block_padder.sv
// Assembles 64-bit message words into padded 576-bit rate blocks
// and hands them downstream over a full/ack handshake.
module sha3_576_block_padder
    import sha3_576_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [63:0]          in,
    input  logic                 in_ready,
    input  logic                 is_last,
    input  logic [2:0]           byte_num,
    input  logic                 f_ack,
    output logic                 ack,
    output logic                 buffer_full,
    output logic [RATE_BITS-1:0] out
);

    logic [3:0]           i;
    logic                 padding;
    logic                 done;
    logic                 ready;
    logic                 take;
    logic                 fill;
    logic                 at_end;
    logic                 closes;
    logic [63:0]          padded;
    logic [63:0]          shift_word;
    logic [RATE_BITS-1:0] next_out;

    sha3_pad_word u_pad (
        .in       (in),
        .byte_num (byte_num),
        .out      (padded)
    );

    assign ready  = ~buffer_full & ~padding & ~done;
    assign take   = in_ready & ready;
    assign fill   = padding & ~buffer_full;
    assign at_end = (i == 4'(RATE_WORDS - 1));

    // A block closes the message when its last slot is a zero-fill
    // word or the padded final word itself.
    always_comb begin
        shift_word = {WORD_BITS{1'b0}};
        if (!fill)
            shift_word = is_last ? padded : in;
        closes   = at_end & (fill | is_last);
        next_out = {out[RATE_BITS-WORD_BITS-1:0], shift_word};
        if (closes)
            next_out[7:0] = next_out[7:0] | FINAL_BIT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out         <= '0;
            buffer_full <= 1'b0;
            ack         <= 1'b0;
            i           <= '0;
            padding     <= 1'b0;
            done        <= 1'b0;
        end else begin
            ack <= take;
            if (buffer_full) begin
                if (f_ack) begin
                    buffer_full <= 1'b0;
                    i           <= '0;
                end
            end else if (take | fill) begin
                out <= next_out;
                i   <= i + 4'd1;
                if (take & is_last)
                    padding <= 1'b1;
                if (at_end) begin
                    buffer_full <= 1'b1;
                    if (closes) begin
                        padding <= 1'b0;
                        done    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sha3_576_block_padder.sv
// Directed bench for sha3_576_block_padder with a byte-queue
// reference model checked every cycle.
module tb_sha3_576_block_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [63:0]  in;
    logic         in_ready;
    logic         is_last;
    logic [2:0]   byte_num;
    logic         f_ack;
    logic         ack;
    logic         buffer_full;
    logic [575:0] out;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    logic [7:0] blk[$];
    bit m_ack, m_full, m_pad, m_done;

    always #5 clk = ~clk;

    sha3_576_block_padder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .f_ack       (f_ack),
        .ack         (ack),
        .buffer_full (buffer_full),
        .out         (out)
    );

    task automatic model_reset();
        m_ack  = 0;
        m_full = 0;
        m_pad  = 0;
        m_done = 0;
        blk.delete();
    endtask

    // Message bytes (plus padding) collected in arrival order.
    task automatic model_update();
        m_ack = 0;
        if (m_full) begin
            if (f_ack) begin
                m_full = 0;
                blk.delete();
            end
        end else if (m_pad) begin
            for (int k = 0; k < 8; k++) blk.push_back(8'h00);
        end else if (!m_done && in_ready) begin
            m_ack = 1;
            if (!is_last) begin
                for (int k = 0; k < 8; k++) blk.push_back(in[63-8*k -: 8]);
            end else begin
                for (int k = 0; k < int'(byte_num); k++)
                    blk.push_back(in[63-8*k -: 8]);
                blk.push_back(8'h06);
                while (blk.size() % 8 != 0) blk.push_back(8'h00);
                m_pad = 1;
            end
        end
        if (!m_full && blk.size() == 72) begin
            m_full = 1;
            if (m_pad) begin
                blk[71] = blk[71] | 8'h80;
                m_pad   = 0;
                m_done  = 1;
            end
        end
    endtask

    function automatic logic [575:0] exp_block();
        logic [575:0] v = '0;
        for (int k = 0; k < 72; k++)
            if (k < blk.size()) v[575-8*k -: 8] = blk[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [575:0] act,
                       input logic [575:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_update();
        @(negedge clk);
        if (ack) ack_cnt++;
        chk("ack", {575'b0, ack}, {575'b0, m_ack});
        chk("buffer_full", {575'b0, buffer_full}, {575'b0, m_full});
        if (m_full) chk("out", out, exp_block());
        #1;
    endtask

    task automatic idle_inputs();
        in       = '0;
        in_ready = 0;
        is_last  = 0;
        byte_num = 0;
        f_ack    = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        step();
        step();
        reset_n = 1;
    endtask

    task automatic wait_full(input int max);
        int n = 0;
        while (!buffer_full && n < max) begin
            step();
            n++;
        end
        chk("full_timeout", {575'b0, buffer_full}, {575'b0, 1'b1});
    endtask

    logic [575:0] lit;
    logic [575:0] empty_blk;
    int a0;

    initial begin
        empty_blk          = '0;
        empty_blk[575:512] = 64'h0600000000000000;
        empty_blk[7:0]     = 8'h80;

        reset_n = 0;
        do_reset();
        chk("rst_out", out, '0);
        chk("rst_full", {575'b0, buffer_full}, '0);

        // single last word, 3 bytes
        a0 = ack_cnt;
        in = 64'h90ABCDEF11111111;
        is_last = 1; byte_num = 3; in_ready = 1;
        step();
        in_ready = 0; is_last = 0;
        wait_full(20);
        lit = '0;
        lit[575:512] = 64'h90ABCD0600000000;
        lit[7:0] = 8'h80;
        chk("t1_out", out, lit);
        chk("t1_model", exp_block(), lit);
        in = 64'h5555555555555555; in_ready = 1;
        repeat (5) step();
        chk("t1_ack_once", 576'(ack_cnt - a0), 576'd1);

        // empty message, data bytes must be masked off
        do_reset();
        in = 64'hFFFFFFFFFFFFFFFF;
        is_last = 1; byte_num = 0; in_ready = 1;
        step();
        in_ready = 0; is_last = 0;
        wait_full(20);
        chk("t2_out", out, empty_blk);
        chk("t2_model", exp_block(), empty_blk);

        // exact fill: last word is the ninth
        do_reset();
        in = 64'h1111111111111111; in_ready = 1;
        repeat (8) step();
        in = 64'hAABBCCDDEEFF0011; is_last = 1; byte_num = 7;
        step();
        in_ready = 0; is_last = 0;
        wait_full(2);
        chk("t3_low", {512'b0, out[63:0]}, {512'b0, 64'hAABBCCDDEEFF0086});
        chk("t3_high", {512'b0, out[575:512]}, {512'b0, 64'h1111111111111111});
        f_ack = 1;
        step();
        f_ack = 0;
        a0 = ack_cnt;
        in = 64'h2222222222222222; in_ready = 1;
        repeat (5) step();
        chk("t3_done", 576'(ack_cnt - a0), 576'd0);

        // 72-byte message then empty trailing block, with backpressure
        do_reset();
        in_ready = 1;
        for (int k = 0; k < 9; k++) begin
            in = {8{8'(k + 1)}};
            step();
        end
        lit = '0;
        for (int k = 0; k < 9; k++) lit[575-64*k -: 64] = {8{8'(k + 1)}};
        chk("t4_full", {575'b0, buffer_full}, {575'b0, 1'b1});
        chk("t4_model", exp_block(), lit);
        a0 = ack_cnt;
        in = 64'h7777777777777777;
        repeat (20) step();
        chk("t4_bp_ack", 576'(ack_cnt - a0), 576'd0);
        chk("t4_bp_out", out, lit);
        chk("t4_no_final", {568'b0, out[7:0]}, {568'b0, 8'h09});
        is_last = 1; byte_num = 0; f_ack = 1;
        step();
        chk("t4_fack_noack", {575'b0, ack}, '0);
        f_ack = 0;
        step();
        chk("t4_ack_after", {575'b0, ack}, {575'b0, 1'b1});
        in_ready = 0; is_last = 0;
        wait_full(20);
        chk("t4_second", out, empty_blk);

        // reset while zero-fill is in progress
        do_reset();
        in = 64'hDEADBEEFCAFEF00D; is_last = 1; byte_num = 2; in_ready = 1;
        step();
        in_ready = 0; is_last = 0;
        repeat (3) step();
        chk("t5_not_full", {575'b0, buffer_full}, '0);
        reset_n = 0;
        model_reset();
        step();
        chk("t5_rst_out", out, '0);
        chk("t5_rst_full", {575'b0, buffer_full}, '0);
        reset_n = 1;
        in = 64'h1122334455667788; is_last = 1; byte_num = 5; in_ready = 1;
        step();
        chk("t5_ready", {575'b0, ack}, {575'b0, 1'b1});
        in_ready = 0; is_last = 0;
        wait_full(20);
        lit = '0;
        lit[575:512] = 64'h1122334455060000;
        lit[7:0] = 8'h80;
        chk("t5_out", out, lit);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
